// File: rtl/jtdsp16_rom_loader.sv
// Byte-stream ROM loader: pairs incoming bytes into 16-bit words and issues
// one programming write per word, keeping a running 16-bit checksum.
module jtdsp16_rom_loader #(
    parameter bit HIFIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [11:0] prog_addr,
    output logic [15:0] prog_data,
    output logic        prog_we,
    output logic        busy,
    output logic        done,
    output logic [15:0] csum
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEN = CW'(1 << AW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] hold_q, hold_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic [DW-1:0] csum_q, csum_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            wcnt_q   <= '0;
            phase_q  <= 1'b0;
            hold_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            csum_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            wcnt_q   <= wcnt_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            csum_q   <= csum_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        wcnt_d   = wcnt_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        csum_d   = csum_q;

        // Address advance and checksum accumulate trail each write by one cycle
        if (we_q) begin
            addr_d = addr_q + AW'(1);
            csum_d = csum_q + data_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    target_d = (len == '0) ? FULL_LEN : CW'(len);
                    wcnt_d   = '0;
                    phase_d  = 1'b0;
                    addr_d   = '0;
                    csum_d   = '0;
                end
            end
            S_LOAD: begin
                if (byte_valid && ready_q) begin
                    if (!phase_q) begin
                        hold_d  = byte_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        data_d  = HIFIRST ? {hold_q, byte_data} : {byte_data, hold_q};
                        we_d    = 1'b1;
                        wcnt_d  = wcnt_q + CW'(1);
                        if (wcnt_d == target_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD);
        done_d  = (state_d == S_DONE);
    end

    assign byte_ready = ready_q;
    assign prog_addr  = addr_q;
    assign prog_data  = data_q;
    assign prog_we    = we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign csum       = csum_q;

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Scoreboard bench for jtdsp16_rom_loader: one instance per byte order, fed
// the same stream, writes checked against a word-list model of each load.
module tb_jtdsp16_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] len;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic [1:0]        byte_ready;
    logic [1:0][11:0]  prog_addr;
    logic [1:0][15:0]  prog_data;
    logic [1:0]        prog_we;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [1:0][15:0]  csum;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [27:0] exp0[$];
    logic [27:0] exp1[$];
    logic [15:0] exp_sum[2];
    logic [7:0]  bytes_a[8192];
    logic [1:0]  prev_we = 2'b00;

    jtdsp16_rom_loader #(.HIFIRST(1'b0)) u_lo (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready[0]), .prog_addr(prog_addr[0]),
        .prog_data(prog_data[0]), .prog_we(prog_we[0]),
        .busy(busy[0]), .done(done[0]), .csum(csum[0])
    );

    jtdsp16_rom_loader #(.HIFIRST(1'b1)) u_hi (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready[1]), .prog_addr(prog_addr[1]),
        .prog_data(prog_data[1]), .prog_we(prog_we[1]),
        .busy(busy[1]), .done(done[1]), .csum(csum[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic pop_chk(input int k);
        logic [27:0] e;
        logic [27:0] got;
        int sz;
        got = {prog_addr[k], prog_data[k]};
        sz = (k == 0) ? exp0.size() : exp1.size();
        chk($sformatf("we_single[%0d]", k), 32'(prev_we[k]), 32'(0));
        if (sz == 0) begin
            n_chk++;
            $display("FAIL unexpected_write[%0d]: got addr %h data %h want no write", k, prog_addr[k], prog_data[k]);
        end else begin
            if (k == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            chk($sformatf("write[%0d]", k), 32'(got), 32'(e));
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data)
    always @(negedge clk) begin
        if (!rst) begin
            if (prog_we[0]) pop_chk(0);
            if (prog_we[1]) pop_chk(1);
        end
        prev_we = rst ? 2'b00 : prog_we;
    end

    // Expected writes: consecutive byte pairs, up to the requested word count
    task automatic load_model(input logic [11:0] len_v, input int nbytes);
        int words;
        int full;
        logic [15:0] w0;
        logic [15:0] w1;
        words = (len_v == 12'd0) ? 4096 : int'(len_v);
        full = nbytes / 2;
        if (full > words) full = words;
        exp_sum[0] = 16'h0;
        exp_sum[1] = 16'h0;
        for (int i = 0; i < full; i++) begin
            w0 = {bytes_a[2*i+1], bytes_a[2*i]};
            w1 = {bytes_a[2*i], bytes_a[2*i+1]};
            exp0.push_back({12'(i), w0});
            exp1.push_back({12'(i), w1});
            exp_sum[0] = exp_sum[0] + w0;
            exp_sum[1] = exp_sum[1] + w1;
        end
    endtask

    task automatic drive_load(input logic [11:0] len_v, input int nbytes, input int gapmin,
                              input int gapmax, input bit poke, output int cycles);
        int c0;
        int tries;
        int g;
        load_model(len_v, nbytes);
        start = 1'b1;
        len = len_v;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        len = 12'($urandom);
        chk("load_flags", 32'({busy, done, byte_ready}), 32'(6'b11_00_11));
        for (int b = 0; b < nbytes; b++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, gapmin)) : 0;
            byte_valid = 1'b0;
            repeat (g) @(negedge clk);
            byte_valid = 1'b1;
            byte_data = bytes_a[b];
            if (poke && b == nbytes / 2) begin
                start = 1'b1;
                len = 12'd1;
            end
            tries = 0;
            while (byte_ready != 2'b11 && tries < 64) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 64) begin
                n_chk++;
                $display("FAIL byte_accept_timeout: got byte_ready %b want 11 for byte %0d", byte_ready, b);
            end
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        cycles = cyc - c0;
    endtask

    task automatic finish_check(input int words, input string tag);
        int tries;
        tries = 0;
        while (done != 2'b11 && tries < 64) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 64) begin
            n_chk++;
            $display("FAIL %s_done_timeout: got done %b want 11", tag, done);
        end
        chk({tag, "_done_flags"}, 32'({busy, byte_ready, done}), 32'(6'b00_00_11));
        chk({tag, "_final_we"}, 32'(prog_we), 32'(2'b11));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_csum[%0d]", tag, k), 32'(csum[k]), 32'(exp_sum[k]));
            chk($sformatf("%s_addr[%0d]", tag, k), 32'(prog_addr[k]), 32'(12'(words)));
        end
        chk({tag, "_q0_empty"}, 32'(exp0.size()), 32'(0));
        chk({tag, "_q1_empty"}, 32'(exp1.size()), 32'(0));
        // Bytes offered in DONE must not be taken
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data = 8'($urandom);
            @(negedge clk);
            chk({tag, "_done_idle"}, 32'({byte_ready, prog_we, done}), 32'(6'b00_00_11));
        end
        byte_valid = 1'b0;
        chk({tag, "_addr_hold"}, 32'(prog_addr[0]), 32'(12'(words)));
        chk({tag, "_csum_hold"}, 32'(csum[1]), 32'(exp_sum[1]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({prog_we, busy, done, byte_ready}), 32'(0));
        chk({tag, "_addr"}, 32'(prog_addr), 32'(0));
        chk({tag, "_data"}, 32'(prog_data), 32'(0));
        chk({tag, "_csum"}, 32'(csum), 32'(0));
    endtask

    initial begin
        int cycles;
        logic [11:0] lv;
        rst = 1'b0;
        start = 1'b0;
        len = 12'd0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("idle_after_reset");

        // Fixed low-first pair stream, back to back
        bytes_a[0] = 8'h34; bytes_a[1] = 8'h12; bytes_a[2] = 8'h78; bytes_a[3] = 8'h56;
        drive_load(12'd2, 4, 0, 0, 1'b0, cycles);
        finish_check(2, "two_words");
        chk("two_words_csum_lo", 32'(csum[0]), 32'(16'h68AC));

        // Single word with 3-cycle gaps between bytes, start poked mid-load
        bytes_a[0] = 8'h12; bytes_a[1] = 8'h34;
        drive_load(12'd1, 2, 3, 3, 1'b1, cycles);
        finish_check(1, "gapped");
        chk("gapped_hi_word", 32'(exp_sum[1]), 32'(16'h1234));

        // Randomised loads with random gaps and restart pokes
        for (int it = 0; it < 5; it++) begin
            lv = 12'($urandom_range(24, 1));
            for (int b = 0; b < 2 * int'(lv); b++) bytes_a[b] = 8'($urandom);
            drive_load(lv, 2 * int'(lv), 0, 3, it[0], cycles);
            finish_check(int'(lv), $sformatf("rand%0d", it));
        end

        // Abort after three bytes of a four-word load
        for (int b = 0; b < 8; b++) bytes_a[b] = 8'($urandom);
        drive_load(12'd4, 3, 0, 0, 1'b0, cycles);
        rst = 1'b1;
        #1 chk_zero("abort");
        chk("abort_q0_empty", 32'(exp0.size()), 32'(0));
        chk("abort_q1_empty", 32'(exp1.size()), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("abort_idle");
        drive_load(12'd4, 8, 0, 2, 1'b0, cycles);
        finish_check(4, "reload");

        // Full 4096-word load streamed back to back
        for (int b = 0; b < 8192; b++) bytes_a[b] = 8'($urandom);
        drive_load(12'd0, 8192, 0, 0, 1'b0, cycles);
        chk("full_cycles", 32'(cycles), 32'(2 * 4096 + 1));
        finish_check(4096, "full");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
